// File: rtl/sdram_stream_master.sv
// sdram_stream_master: linear block-transfer initiator for the SDRAM controller
// command FIFO. Write transfers turn a 16-bit stream into write commands; read
// transfers issue read commands under a credit limit and return readouts in
// order through a first-word-fall-through buffer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; readouts arriving here are dropped
// WRITE | one write command per accepted stream word while not full
// READ  | read commands while credits remain and not full
// DRAIN | all reads issued; wait for in-flight and buffered words to clear
// DONE  | one-cycle completion pulse, then back to IDLE
module sdram_stream_master #(
    parameter int CREDITS = 16,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic             reqIsWrite,
    input  logic [24:0]      reqAddr,
    input  logic [LEN_W-1:0] reqLen,
    input  logic             wdValid,
    output logic             wdReady,
    input  logic [15:0]      wdData,
    output logic             rdValid,
    input  logic             rdReady,
    output logic [15:0]      rdData,
    output logic [24:0]      rdAddr,
    output logic             done,
    output logic             rdErr,
    output logic             write,
    input  logic             full,
    output logic             isWrite,
    output logic [24:0]      address,
    output logic [1:0]       writeMask,
    output logic [15:0]      writeData,
    output logic             keepOpen,
    input  logic             readValid,
    input  logic [24:0]      raddr,
    input  logic [15:0]      rdata
);
    localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [24:0]      cur_q, cur_d;
    logic [24:0]      exp_q, exp_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             err_q, err_d;
    logic [40:0]      buf_mem [CREDITS];

    logic             issue;
    logic             credit_ok;
    logic             capture;
    logic             push;
    logic             pop;
    logic [CW:0]      used;

    // Command issue, readout capture and next-state / counter updates.
    always_comb begin
        used      = {1'b0, inflight_q} + {1'b0, count_q};
        credit_ok = used < (CW+1)'(CREDITS);
        issue     = 1'b0;
        if (state_q == S_WRITE) begin
            issue = wdValid & ~full;
        end else if (state_q == S_READ) begin
            issue = ~full & credit_ok;
        end
        capture = readValid & (state_q != S_IDLE);
        push    = capture & (inflight_q != '0);
        pop     = (count_q != '0) & rdReady;

        state_d    = state_q;
        cur_d      = cur_q;
        exp_d      = exp_q;
        remain_d   = remain_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_d      = err_q;

        // Readouts are only trusted when a read is outstanding; the address
        // check is advisory, the word is always delivered.
        if (push) begin
            inflight_d = inflight_d - CW'(1);
            exp_d      = exp_q + 25'd1;
            wptr_d     = wptr_q + PW'(1);
            count_d    = count_d + CW'(1);
            if (raddr != exp_q) begin
                err_d = 1'b1;
            end
        end else if (capture) begin
            err_d = 1'b1;
        end
        if (pop) begin
            rptr_d  = rptr_q + PW'(1);
            count_d = count_d - CW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    cur_d    = reqAddr;
                    exp_d    = reqAddr;
                    remain_d = reqLen;
                    err_d    = 1'b0;
                    if (reqLen == '0) begin
                        state_d = S_DONE;
                    end else if (reqIsWrite) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE, S_READ: begin
                if (issue) begin
                    cur_d    = cur_q + 25'd1;
                    remain_d = remain_q - LEN_W'(1);
                    if (state_q == S_READ) begin
                        inflight_d = inflight_d + CW'(1);
                    end
                    if (remain_q == LEN_W'(1)) begin
                        state_d = (state_q == S_WRITE) ? S_DONE : S_DRAIN;
                    end
                end
            end
            // Uses next-cycle counts so done follows the final pop directly.
            S_DRAIN: begin
                if (inflight_d == '0 && count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            exp_q      <= '0;
            remain_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            exp_q      <= exp_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    // Read buffer storage; contents need no reset since count gates rdValid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wptr_q] <= {raddr, rdata};
        end
    end

    assign reqReady  = (state_q == S_IDLE);
    assign write     = issue;
    assign wdReady   = issue & (state_q == S_WRITE);
    assign isWrite   = (state_q == S_WRITE);
    assign address   = cur_q;
    assign writeMask = 2'b11;
    assign writeData = (state_q == S_WRITE) ? wdData : 16'h0000;
    assign keepOpen  = ((state_q == S_WRITE) || (state_q == S_READ)) && (remain_q > LEN_W'(1));
    assign done      = (state_q == S_DONE);
    assign rdErr     = err_q;
    assign rdValid   = (count_q != '0);
    assign rdData    = buf_mem[rptr_q][15:0];
    assign rdAddr    = buf_mem[rptr_q][40:16];

endmodule

// File: tb/tb_sdram_stream_master.sv
// Bench for sdram_stream_master: scripted scenarios plus randomized transfers
// against a transfer-level reference model and a behavioural controller model.
module tb_sdram_stream_master;
    localparam int CREDITS = 16;
    localparam int LEN_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             reqValid = 1'b0;
    logic             reqReady;
    logic             reqIsWrite = 1'b0;
    logic [24:0]      reqAddr = '0;
    logic [LEN_W-1:0] reqLen = '0;
    logic             wdValid = 1'b0;
    logic             wdReady;
    logic [15:0]      wdData = '0;
    logic             rdValid;
    logic             rdReady = 1'b0;
    logic [15:0]      rdData;
    logic [24:0]      rdAddr;
    logic             done;
    logic             rdErr;
    logic             write;
    logic             full = 1'b0;
    logic             isWrite;
    logic [24:0]      address;
    logic [1:0]       writeMask;
    logic [15:0]      writeData;
    logic             keepOpen;
    logic             readValid = 1'b0;
    logic [24:0]      raddr = '0;
    logic [15:0]      rdata = '0;

    sdram_stream_master #(.CREDITS(CREDITS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqIsWrite(reqIsWrite),
        .reqAddr(reqAddr), .reqLen(reqLen),
        .wdValid(wdValid), .wdReady(wdReady), .wdData(wdData),
        .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .rdAddr(rdAddr),
        .done(done), .rdErr(rdErr),
        .write(write), .full(full), .isWrite(isWrite), .address(address),
        .writeMask(writeMask), .writeData(writeData), .keepOpen(keepOpen),
        .readValid(readValid), .raddr(raddr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // transfer-level reference state
    bit          x_w;
    logic [24:0] x_a;
    int          x_n;
    bit          x_err;
    bit          xfer_active = 0;
    bit          done_seen = 0;
    int          cmd_idx = 0;
    int          pop_idx = 0;
    int          accept_cyc = 0;
    int          first_cmd_cyc = 0;
    int          last_cmd_cyc = 0;
    int          last_pop_cyc = 0;
    bit          prev_done = 0;

    // stream source and knobs
    logic [15:0] wd_list [64];
    int          wd_idx = 0;
    int          wd_len = 0;
    int          wd_prob = 100;
    int          full_prob = 0;
    int          rr_prob = 100;
    int          stop_after = 0;
    int          rlat_min = 1;
    int          rlat_max = 3;
    bit          inject = 0;

    // memories: ref_mem from the transfer model, ctrl_mem from observed commands
    logic [15:0] ref_mem  [logic [24:0]];
    logic [15:0] ctrl_mem [logic [24:0]];

    typedef struct {
        logic [24:0] a;
        int          due;
    } rd_t;
    rd_t ctrl_q [$];

    function automatic logic [15:0] ref_rd(input logic [24:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a[15:0] ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ctrl_rd(input logic [24:0] a);
        return ctrl_mem.exists(a) ? ctrl_mem[a] : (a[15:0] ^ 16'h5A5A);
    endfunction

    // input driver and controller readout model
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            #1;
            wdValid = (wd_idx < wd_len) && ($urandom_range(1, 100) <= wd_prob);
            wdData  = (wd_idx < wd_len) ? wd_list[wd_idx] : 16'($urandom);
            full    = (stop_after > 0 && cmd_idx >= stop_after) ? 1'b1
                      : ($urandom_range(1, 100) <= full_prob);
            rdReady = ($urandom_range(1, 100) <= rr_prob);
            readValid = 1'b0;
            raddr     = 25'($urandom);
            rdata     = 16'($urandom);
            if (ctrl_q.size() > 0 && ctrl_q[0].due <= cyc) begin
                e = ctrl_q.pop_front();
                readValid = 1'b1;
                raddr     = (inject && e.a == 25'h204) ? 25'h205 : e.a;
                rdata     = ctrl_rd(e.a);
            end
        end
    end

    // monitor: every command, pop and completion against the transfer model
    always @(negedge clk) begin : mon
        rd_t         ent;
        logic [24:0] ea;
        logic [24:0] exp_ra;
        if (!rst) begin
            if (write) begin
                if (!xfer_active) begin
                    check_val("wr_idle", 1, 0);
                end else begin
                    check_val("wr_full", full, 0);
                    check_val("cmd_cnt", cmd_idx < x_n, 1);
                    check_val("cmd_type", isWrite, x_w);
                    check_val("cmd_addr", address, 25'(x_a + 25'(cmd_idx)));
                    check_val("keep", keepOpen, (x_n - cmd_idx) > 1);
                    if (x_w) begin
                        check_val("wdata", writeData, wd_list[cmd_idx]);
                        check_val("wd_hs", {wdValid, wdReady}, 2'b11);
                        ctrl_mem[address] = writeData;
                        wd_idx++;
                    end else begin
                        check_val("credit", (cmd_idx - pop_idx) < CREDITS, 1);
                        ent.a   = address;
                        ent.due = cyc + $urandom_range(rlat_min, rlat_max);
                        ctrl_q.push_back(ent);
                    end
                    if (cmd_idx == 0) first_cmd_cyc = cyc;
                    last_cmd_cyc = cyc;
                    cmd_idx++;
                end
            end
            if (rdValid) begin
                if (!xfer_active) begin
                    check_val("rv_idle", 1, 0);
                end else if (rdReady) begin
                    ea     = 25'(x_a + 25'(pop_idx));
                    exp_ra = (inject && ea == 25'h204) ? 25'h205 : ea;
                    check_val("rd_cnt", pop_idx < (x_w ? 0 : x_n), 1);
                    check_val("rd_addr", rdAddr, exp_ra);
                    check_val("rd_data", rdData, ref_rd(ea));
                    last_pop_cyc = cyc;
                    pop_idx++;
                end
            end
            if (prev_done) check_val("ready_after_done", reqReady, 1);
            if (reqValid && reqReady) accept_cyc = cyc;
            if (done) begin
                if (!xfer_active || done_seen) begin
                    check_val("done_unexp", 1, 0);
                end else begin
                    check_val("done_cyc", cyc, (x_n == 0) ? accept_cyc + 1
                              : (x_w ? last_cmd_cyc + 1 : last_pop_cyc + 1));
                    check_val("done_cmds", cmd_idx, x_n);
                    check_val("done_pops", pop_idx, x_w ? 0 : x_n);
                    check_val("done_err", rdErr, x_err);
                    done_seen   = 1;
                    xfer_active = 0;
                end
            end
            prev_done = done;
        end
    end

    task automatic start_xfer(input bit w, input logic [24:0] a, input int n,
                              input bit seq, input bit e);
        cmd_idx = 0;
        pop_idx = 0;
        wd_idx  = 0;
        for (int i = 0; i < n; i++) begin
            wd_list[i] = seq ? 16'(32'hA0 + i) : 16'($urandom);
            if (w) ref_mem[25'(a + 25'(i))] = wd_list[i];
        end
        x_w = w; x_a = a; x_n = n; x_err = e;
        wd_len = w ? n : 0;
        done_seen = 0;
        xfer_active = 1;
        @(posedge clk);
        #1;
        reqValid = 1'b1; reqIsWrite = w; reqAddr = a; reqLen = LEN_W'(n);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (reqReady) break;
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("done_seen", done_seen, 1);
    endtask

    task automatic wait_cmds(input int k, input int budget);
        for (int i = 0; i < budget && cmd_idx < k; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("cmd_reach", cmd_idx >= k, 1);
    endtask

    initial begin
        bit          any_rv;
        bit          w;
        bit          have_wr;
        int          n;
        logic [24:0] a;
        logic [24:0] last_wa;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready", reqReady, 1);
        check_val("rst_strobes", {write, wdReady, rdValid, done, rdErr, keepOpen}, 6'b0);
        check_val("rst_cmd", {isWrite, address, writeData}, 42'h0);
        check_val("rst_mask", writeMask, 2'b11);

        // four-word write with sequential data
        start_xfer(1, 25'h10, 4, 1, 0);
        wait_done(100);
        check_val("t1_first", first_cmd_cyc, accept_cyc + 1);
        check_val("t1_burst", last_cmd_cyc, first_cmd_cyc + 3);

        // credit limit with no consumer, then drain
        rr_prob = 0;
        start_xfer(0, 25'h100, 40, 0, 0);
        repeat (60) @(negedge clk);
        #1;
        check_val("t2_credit_cmds", cmd_idx, CREDITS);
        check_val("t2_wr_low", write, 0);
        check_val("t2_rv", rdValid, 1);
        rr_prob = 100;
        wait_done(500);

        // five-cycle full stall mid-write
        stop_after = 2;
        start_xfer(1, 25'h40, 8, 0, 0);
        wait_cmds(2, 50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t3_stall", {write, wdReady}, 2'b00);
            check_val("t3_frozen", address, 25'h42);
        end
        stop_after = 0;
        wait_done(100);

        // readout address mismatch, sticky error
        inject = 1;
        start_xfer(0, 25'h200, 8, 0, 1);
        wait_done(300);
        @(negedge clk);
        check_val("t4_sticky", rdErr, 1);
        inject = 0;

        // address wrap; accept clears rdErr
        start_xfer(1, 25'h1FFFFFE, 3, 0, 0);
        @(negedge clk);
        check_val("t5_err_clr", rdErr, 0);
        wait_done(100);

        // empty transfer
        start_xfer(0, 25'h55, 0, 0, 0);
        wait_done(20);

        // reset with five reads outstanding
        rlat_min = 10; rlat_max = 10;
        stop_after = 5;
        start_xfer(0, 25'h300, 10, 0, 0);
        wait_cmds(5, 50);
        @(posedge clk);
        #1 rst = 1'b1;
        xfer_active = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stop_after = 0;
        any_rv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_rv |= rdValid;
        end
        check_val("t6_rv", any_rv, 0);
        check_val("t6_err", rdErr, 0);
        check_val("t6_ready", reqReady, 1);
        rlat_min = 1; rlat_max = 3;

        // randomized transfers
        have_wr = 0;
        last_wa = '0;
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: n = 0;
                1: n = 1;
                2: n = 2;
                default: n = $urandom_range(3, 40);
            endcase
            if (!w && have_wr && $urandom_range(0, 1) == 1) a = last_wa;
            else if ($urandom_range(0, 3) == 0) a = 25'h1FFFFF0 + 25'($urandom_range(0, 15));
            else a = 25'($urandom);
            wd_prob   = $urandom_range(30, 100);
            full_prob = $urandom_range(0, 50);
            rr_prob   = $urandom_range(20, 100);
            rlat_max  = $urandom_range(1, 8);
            start_xfer(w, a, n, 0, 0);
            wait_done(3000);
            if (w) begin
                last_wa = a;
                have_wr = 1;
            end
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_stream_master.md
# sdram_stream_master

Block-transfer initiator for the SDRAM controller's command-FIFO interface. It accepts one linear transfer request (start address, word count, direction) at a time. Write transfers turn an incoming 16-bit data stream into FIFO write commands. Read transfers issue FIFO read commands under a credit limit and return the controller's readouts, in order, on a back-pressured output stream. It sits between user logic (frame buffer, DMA, memory tester) and the controller instance.

## Interface
Parameters:
- CREDITS, 16: max read words in flight plus buffered; also the read-buffer depth (power of 2, 2..256).
- LEN_W, 16: width of the request length field.

Ports:
- clk  in  1  system clock, same clock as the controller.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  1  transfer request present.
- reqReady  out  1  high only in IDLE; a request is accepted when reqValid & reqReady.
- reqIsWrite  in  1  1 = write transfer, 0 = read transfer.
- reqAddr  in  25  first word address.
- reqLen  in  LEN_W  number of words; 0 = empty transfer.
- wdValid  in  1  write stream word present.
- wdReady  out  1  write word consumed this cycle.
- wdData  in  16  write word; always written with writeMask 2'b11.
- rdValid  out  1  read-back word present.
- rdReady  in  1  consumer takes the word.
- rdData  out  16  read-back data.
- rdAddr  out  25  address the word came from.
- done  out  1  one-cycle pulse when a transfer completes.
- rdErr  out  1  sticky readout-address mismatch or unexpected readout; cleared on request accept.
- write  out  1  controller FIFO write strobe.
- full  in  1  controller FIFO full.
- isWrite  out  1  FIFO command type.
- address  out  25  FIFO command address.
- writeMask  out  2  constant 2'b11.
- writeData  out  16  FIFO write data.
- keepOpen  out  1  hint to the controller to hold the row open.
- readValid  in  1  controller readout valid.
- raddr  in  25  readout address.
- rdata  in  16  readout data.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On accept, latch the direction.
  - Latch cur = reqAddr, remain = reqLen, expAddr = reqAddr.
  - Clear rdErr.
  - If reqLen == 0, go to DONE. Otherwise go to WRITE or READ.
- WRITE:
  - write = wdReady = wdValid & ~full.
  - isWrite = 1, address = cur, writeData = wdData.
  - On each issue: cur++ and remain--. When remain reaches 0, go to DONE.
- READ:
  - write = ~full & (inflight + bufCount < CREDITS).
  - isWrite = 0, address = cur.
  - On each issue: cur++, remain--, inflight++. When remain reaches 0, go to DRAIN.
- DRAIN: wait for inflight == 0 and bufCount == 0, then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Readout capture, active in every state except IDLE:
  - On readValid with inflight > 0, push {raddr, rdata} into the read buffer, decrement inflight and increment expAddr.
  - If raddr != expAddr, set rdErr; the word is still delivered.
  - On readValid with inflight == 0, discard the word and set rdErr.
  - In IDLE, readouts are discarded silently.
- Read buffer: FWFT FIFO of depth CREDITS. rdValid = ~empty. A pop occurs on rdValid & rdReady. The credit rule guarantees the buffer never overflows.
- keepOpen = 1 in WRITE and READ while remain > 1; otherwise 0.
- Arithmetic:
  - cur and expAddr are 25 bits and wrap 0x1FFFFFF -> 0.
  - remain is LEN_W bits.
  - inflight and bufCount are log2(CREDITS)+1 bits.
- Simultaneous events:
  - An issue and a readout in the same cycle leave inflight unchanged.
  - A push and a pop in the same cycle leave bufCount unchanged.
- Reset mid-transfer abandons the transfer. Readouts from commands already queued in the controller arrive in IDLE and are dropped. No done pulse is generated.

## Timing
- Reset values:
  - reqReady = 1 (from the cycle after reset).
  - write = wdReady = rdValid = done = rdErr = keepOpen = 0.
  - isWrite = 0, address = 0, writeData = 0, writeMask = 2'b11.
  - Read buffer empty.
- Request accept to first command: 1 cycle (the command may issue in the first WRITE/READ cycle).
- Throughput: 1 command per cycle while not full and, for reads, while credits are available.
- write, wdReady, address and isWrite are combinational from state/registers and full. The controller samples them at the clock edge.
- Readout to rdValid: 1 cycle (registered push, FWFT output).
- done asserts the cycle after:
  - the last write issues, or
  - for reads, the cycle after the last buffered word pops.
- reqReady reasserts the cycle after done.

## Test plan
- Write reqAddr=0x10, reqLen=4, data 0xA0..0xA3 with full=0 -> write high on 4 consecutive cycles, addresses 0x10..0x13, done 1 cycle after the last write, keepOpen high for the first 3 issues.
- Read reqAddr=0x100, reqLen=40, CREDITS=16, rdReady=0 -> exactly 16 read commands issue and then write stays low. Raising rdReady drains data in order with rdAddr 0x100..0x127, and done pulses after the 40th pop.
- full held high for 5 cycles mid-write -> no write, no wdReady, cur frozen. The transfer resumes at the next address with no loss.
- Controller model returns raddr=0x205 when 0x204 is expected -> rdErr=1 sticky and the word is delivered. The next request accept clears rdErr.
- reqAddr=0x1FFFFFE, reqLen=3 write -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
- reqLen=0 -> no commands, done pulses 1 cycle after accept. Then rst asserted during a 10-word read with 5 in flight -> the 5 late readouts are dropped, rdValid=0, rdErr=0, reqReady=1.
